// File: rtl/onehot_event_encoder.sv
// onehot_event_encoder: sticky 4-line event capture encoded to a 2-bit index with a valid/ready output register.
// Define ONEHOT_RR_ARB_EN for round-robin arbitration; otherwise fixed priority, lowest index first.
module onehot_event_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Y3,
    input  logic       Y2,
    input  logic       Y1,
    input  logic       Y0,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       S1,
    output logic       S0,
    output logic       D,
    output logic [3:0] pending,
    output logic       overflow
);
    logic [3:0] y, clr;
    logic [1:0] sel;
    logic       load, hit;
    assign y    = {Y3, Y2, Y1, Y0};
    assign load = !out_valid || out_ready;
`ifdef ONEHOT_RR_ARB_EN
    logic [1:0] ptr;
    // Walk downward so the line closest after ptr overwrites any later candidate
    always_comb begin
        sel = 2'd0;
        hit = 1'b0;
        for (int k = 3; k >= 0; k--)
            if (pending[ptr + 2'(k)]) begin
                sel = ptr + 2'(k);
                hit = 1'b1;
            end
    end
    always_ff @(posedge clk)
        if (!rst_n) ptr <= 2'd0;
        else if (load && hit) ptr <= sel + 2'd1;
`else
    assign hit = |pending;
    assign sel = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
`endif
    assign clr = (load && hit) ? 4'b0001 << sel : 4'b0000;
    always_ff @(posedge clk)
        if (!rst_n) begin
            pending   <= 4'b0000;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            {S1, S0}  <= 2'b00;
            D         <= 1'b0;
        end else begin
            pending  <= y | (pending & ~clr);
            overflow <= |(y & pending & ~clr);
            if (load) begin
                out_valid <= hit;
                {S1, S0}  <= hit ? sel : 2'b00;
                D         <= hit;
            end
        end
endmodule

// File: tb/tb_onehot_event_encoder.sv
// tb_onehot_event_encoder: directed and random steps checked against a behavioural model of the encoder.
module tb_onehot_event_encoder;
    logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic Y3 = 1'b0, Y2 = 1'b0, Y1 = 1'b0, Y0 = 1'b0;
    logic out_valid, S1, S0, D, overflow;
    logic [3:0] pending;
    int passed = 0, total = 0;
    int m_pend[4];
    int m_valid, m_idx, m_ptr, m_ovf;

    onehot_event_encoder dut (
        .clk(clk), .rst_n(rst_n), .Y3(Y3), .Y2(Y2), .Y1(Y1), .Y0(Y0),
        .out_ready(out_ready), .out_valid(out_valid), .S1(S1), .S0(S0), .D(D),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Model: the reporting order is a search over the pending lines starting at
    // the round-robin origin (or at 0 for fixed priority).
    task automatic model(input logic [3:0] y, input logic rdy, input logic rn);
        int sel;
        int lines;
        sel = -1;
        if (!rn) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_valid = 0; m_idx = 0; m_ptr = 0; m_ovf = 0;
            return;
        end
        if (m_valid == 0 || rdy) begin
            for (int k = 0; k < 4; k++) begin
`ifdef ONEHOT_RR_ARB_EN
                lines = (m_ptr + k) % 4;
`else
                lines = k;
`endif
                if (sel < 0 && m_pend[lines] == 1) sel = lines;
            end
            m_valid = (sel >= 0);
            m_idx   = (sel >= 0) ? sel : 0;
            if (sel >= 0) m_ptr = (sel + 1) % 4;
        end
        m_ovf = 0;
        for (int i = 0; i < 4; i++) begin
            if (y[i] && m_pend[i] == 1 && sel != i) m_ovf = 1;
            if (y[i]) m_pend[i] = 1;
            else if (sel == i) m_pend[i] = 0;
        end
    endtask

    task automatic step(input logic [3:0] y, input logic rdy, input logic rn);
        logic [3:0] mp;
        {Y3, Y2, Y1, Y0} = y;
        out_ready = rdy;
        rst_n = rn;
        model(y, rdy, rn);
        @(posedge clk);
        #1;
        mp = {m_pend[3][0], m_pend[2][0], m_pend[1][0], m_pend[0][0]};
        chk("out_valid", 8'(out_valid), 8'(m_valid));
        chk("index", 8'({S1, S0}), 8'(m_idx));
        chk("D", 8'(D), 8'(m_valid));
        chk("pending", 8'(pending), 8'(mp));
        chk("overflow", 8'(overflow), 8'(m_ovf));
    endtask

    initial begin
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        chk("reset_all", {out_valid, S1, S0, D, pending}, 8'h00);
        step(4'b0100, 1'b1, 1'b1);
        chk("y2_capture", {out_valid, overflow, pending}, 8'h04);
        step(4'b0000, 1'b1, 1'b1);
        chk("y2_code", {4'b0, out_valid, S1, S0, D}, 8'h0D);
        step(4'b0000, 1'b1, 1'b1);
        chk("y2_done", {out_valid, overflow, S1, S0, D}, 8'h00);
        step(4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1'b1, 1'b1);
            chk("burst_idx", {out_valid, S1, S0}, 8'(4 + i));
        end
        step(4'b0000, 1'b1, 1'b1);
        chk("burst_end", 8'(out_valid), 8'h00);
        for (int i = 0; i < 6; i++) step(4'b0011, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("held_code", {out_valid, S1, S0, D}, 8'h0B);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        chk("no_ovf_presented", {overflow, pending}, 8'h02);
        step(4'b0010, 1'b0, 1'b1);
        chk("ovf_pulse", {overflow, out_valid, S1, S0, D}, 8'h1B);
        step(4'b0000, 1'b0, 1'b1);
        chk("ovf_cleared", 8'(overflow), 8'h00);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        chk("y0_setwins", {overflow, pending}, 8'h01);
        step(4'b0000, 1'b1, 1'b1);
        chk("y0_second", {out_valid, S1, S0, D}, 8'h09);
        step(4'b1011, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        chk("mid_reset", {out_valid, S1, S0, D, pending}, 8'h00);
        step(4'b0000, 1'b1, 1'b1);
        chk("after_reset", {out_valid, overflow, pending}, 8'h00);
        for (int i = 0; i < 400; i++)
            step(4'($urandom), ($urandom % 4) != 0, ($urandom % 50) != 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
